// File: rtl/window_extreme_tracker.sv
// Streaming window max/min tracker: MSB-first magnitude compare feeds the extreme registers,
// result presented under valid/ready. Optional min tracking enabled by defining TRACK_MIN_EN.
module window_extreme_tracker #(
  parameter int unsigned SIZE   = 8,
  parameter int unsigned WINDOW = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [SIZE-1:0]  sample_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [SIZE-1:0]  max_val_o,
  output logic [IDX_W-1:0] max_idx_o,
  output logic [SIZE-1:0]  min_val_o
);

  localparam int unsigned      CNT_W   = IDX_W + 1;
  localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] count_inc;
  logic [SIZE-1:0]  max_q, max_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             gt_max;
`ifdef TRACK_MIN_EN
  logic [SIZE-1:0]  min_q, min_d;
  logic             lt_min;
`endif

  // MSB-first unsigned compare: the first differing bit from the top decides a > b
  function automatic logic mag_gt(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    logic gt;
    logic decided;
    gt      = 1'b0;
    decided = 1'b0;
    for (int i = int'(SIZE) - 1; i >= 0; i--) begin
      if (!decided && (a[i] != b[i])) begin
        gt      = a[i];
        decided = 1'b1;
      end
    end
    return gt;
  endfunction

  assign count_inc = count_q + ONE_CNT;
  assign gt_max    = mag_gt(sample_i, max_q);
`ifdef TRACK_MIN_EN
  assign lt_min    = mag_gt(min_q, sample_i);
`endif

  // Next-state and register-update selection
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    max_d   = max_q;
    idx_d   = idx_q;
`ifdef TRACK_MIN_EN
    min_d   = min_q;
`endif
    if (clear_i) begin
      state_d = ST_EMPTY;
      count_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_valid_i) begin
            max_d   = sample_i;
            idx_d   = '0;
`ifdef TRACK_MIN_EN
            min_d   = sample_i;
`endif
            count_d = ONE_CNT;
            state_d = (ONE_CNT == WIN_CNT) ? ST_REPORT : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (in_valid_i) begin
            // Strictly greater only, so ties keep the earlier index
            if (gt_max) begin
              max_d = sample_i;
              idx_d = count_q[IDX_W-1:0];
            end
`ifdef TRACK_MIN_EN
            if (lt_min) begin
              min_d = sample_i;
            end
`endif
            count_d = count_inc;
            if (count_inc == WIN_CNT) begin
              state_d = ST_REPORT;
            end
          end
        end
        ST_REPORT: begin
          if (out_ready_i) begin
            state_d = ST_EMPTY;
            count_d = '0;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_EMPTY;
      count_q <= '0;
      max_q   <= '0;
      idx_q   <= '0;
`ifdef TRACK_MIN_EN
      min_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
`ifdef TRACK_MIN_EN
      min_q   <= min_d;
`endif
    end
  end

  assign in_ready_o  = (state_q != ST_REPORT);
  assign out_valid_o = (state_q == ST_REPORT);
  assign max_val_o   = max_q;
  assign max_idx_o   = idx_q;
`ifdef TRACK_MIN_EN
  assign min_val_o   = min_q;
`else
  assign min_val_o   = '0;
`endif

endmodule

// File: doc/window_extreme_tracker.md
# window_extreme_tracker

Streaming window min/max tracker that consumes the greater/less/equal decisions of the team's MSB-first unsigned magnitude-compare stage. Accepts one sample per handshake, holds the running maximum (with the index of its first occurrence) and the running minimum over a fixed window of samples, then presents the result under a valid/ready handshake before starting the next window. It sits directly downstream of the comparator: each incoming sample is compared against the stored extreme, and the compare outcome selects the register update.

## Interface
- `size`, 8: sample width in bits; comparison is unsigned.
- `window`, 4: samples per window; legal range 1..2^`idx_w`.
- `idx_w`, 2: width of the sample-index output.

- `clock`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low; clears all state immediately.
- `clear`  input  1  synchronous; discards a partial window or a pending result.
- `in_valid`  input  1  `sample` is valid.
- `in_ready`  output  1  block can accept a sample.
- `sample`  input  `size`  input sample.
- `out_valid`  output  1  window result is valid.
- `out_ready`  input  1  consumer takes the result.
- `max_val`  output  `size`  window maximum.
- `max_idx`  output  `idx_w`  position in the window (0-based) of the first occurrence of the maximum.
- `min_val`  output  `size`  window minimum (see Configuration).

## Operation
- Accept occurs on an edge where `in_valid & in_ready` is true. Output transfer occurs on an edge where `out_valid & out_ready` is true.
- `in_ready` = (state != REPORT); it is a combinational decode of registered state.
- `out_valid` = (state == REPORT).
- EMPTY:
  - On accept: `max_val` = `min_val` = `sample`, `max_idx` = 0, count = 1.
  - If `window` == 1, go to REPORT; otherwise go to ACCUM.
- ACCUM:
  - On accept, compare `sample` against `max_val`. If `sample` > `max_val` (strictly greater), load `max_val` and set `max_idx` = count. On a tie, keep the earlier index.
  - If `sample` < `min_val`, load `min_val`.
  - count increments. When the new count equals `window`, go to REPORT.
- REPORT:
  - `max_val`, `max_idx` and `min_val` are held stable.
  - On output transfer, go to EMPTY.
  - `in_valid` is ignored in this state; no accept can occur.
- `clear`: state goes to EMPTY and count to 0. `out_valid` drops on the next edge. Stored values keep their last contents. `clear` has priority over a simultaneous accept or transfer.
- The count register is `idx_w`+1 bits wide; it never wraps within a window.

## Timing
- Reset values: state EMPTY, count 0, `max_val` 0, `max_idx` 0, `min_val` 0, `out_valid` 0, `in_ready` 1.
- Latency: the last sample of a window is accepted at edge k; `out_valid` is 1 after edge k and the result reflects that sample.
- Throughput: `window` accept cycles plus at least one REPORT cycle per window. There is no overlap between windows.
- `out_ready` held high gives exactly one REPORT cycle; `in_ready` returns to 1 after the transfer edge.
- Backpressure: `out_valid` and the result hold indefinitely while `out_ready` = 0.
- `reset` asserted mid-window or mid-REPORT: all outputs take their reset values asynchronously, and the partial window is lost.
- `in_valid` may toggle freely; idle cycles inside a window do not alter state.

## Configuration
- `TRACK_MIN_EN` defined: min tracking is present as described above.
- `TRACK_MIN_EN` undefined: no min register and no less-than path exist; `min_val` is a constant 0. Max, index and handshake behaviour are unchanged.

## Test plan
- Window=4, samples 3, 9, 9, 1 with `out_ready`=1 -> one `out_valid` pulse with `max_val`=9, `max_idx`=1, `min_val`=1; `in_ready` low for exactly that cycle.
- Same samples with `out_ready`=0 for 5 cycles -> result and `out_valid` stable for 5 cycles; a sample offered during REPORT is not accepted. After the transfer, the next window starts at index 0.
- `reset` pulsed low after 2 of 4 samples (5, 200) -> outputs 0 immediately. A following window 7, 7, 7, 7 yields `max_val`=7, `max_idx`=0, `min_val`=7.
- `clear` asserted on the same edge as the 3rd accept -> that sample is dropped. A subsequent 4 samples 0, 255, 128, 255 yield max 255, idx 1, min 0.
- Window=1, samples 42 then 17 back-to-back with `out_ready`=1 -> alternating accept/REPORT cycles giving results (42, idx 0) and (17, idx 0).
- `TRACK_MIN_EN` undefined, samples 3, 9, 9, 1 -> `max_val`=9, `max_idx`=1, `min_val`=0.
